// File: rtl/mul_iter_if.sv
// Init-stage to accumulate-stage bus for the iterative multiplier.
// The init stage is the master; mul_iter is the slave that returns the result.
interface mul_iter_if #(
    parameter int TAG_W = 5
);
    logic             start;
    logic             kill;
    logic [63:0]      prod;
    logic [31:0]      rs1_u;
    logic [31:0]      rs2_u;
    logic             sign;
    logic [1:0]       cycles;
    logic [1:0]       mul_op;
    logic [TAG_W-1:0] tag_in;
    logic             ready;
    logic             done;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start, kill, prod, rs1_u, rs2_u, sign, cycles, mul_op, tag_in,
        input  ready, done, result, tag_out
    );

    modport slave (
        input  start, kill, prod, rs1_u, rs2_u, sign, cycles, mul_op, tag_in,
        output ready, done, result, tag_out
    );
endinterface

// File: rtl/mul_iter.sv
// Accumulates the remaining rs2 chunks onto the init partial sum, negates, picks the result word.
// Latency: done 1/2/3 cycles after accept for cycles=0/1/2.
// Backpressure: ready low while accumulating; start is ignored then, and kill drops everything.
module mul_iter #(
    parameter int CHUNK = 11,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    mul_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    typedef struct packed {
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic             sign;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } op_t;

    state_t           state, state_nxt;
    op_t              op_q;
    logic [63:0]      acc;
    logic [1:0]       rem;
    logic [1:0]       idx;
    logic [31:0]      result_q;
    logic [TAG_W-1:0] tag_q;

    logic             ready;
    logic             accept;
    logic             last;
    logic [1:0]       cyc_eff;
    logic [31:0]      rs2_sh;
    logic [CHUNK-1:0] chunk_bits;
    logic [63:0]      partial;
    logic [63:0]      acc_sum;
    logic [63:0]      acc_nxt;

    function automatic logic [31:0] pick_word(input logic [63:0] v, input logic [1:0] op);
        return (op == 2'b00) ? v[31:0] : v[63:32];
    endfunction

    always_comb begin
        ready      = (state != ACC);
        accept     = bus.start && ready && !bus.kill;
        last       = (rem == 2'd1);
        // cycles=3 is illegal and folded onto the longest legal sequence
        cyc_eff    = (bus.cycles == 2'd3) ? 2'd2 : bus.cycles;
        rs2_sh     = op_q.rs2 >> (CHUNK * int'(idx));
        chunk_bits = rs2_sh[CHUNK-1:0];
        partial    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk_bits[i]) begin
                partial = partial + (64'(op_q.rs1) << i);
            end
        end
        acc_sum = acc + (partial << (CHUNK * int'(idx)));
        acc_nxt = (op_q.sign && last) ? (~acc_sum + 64'd1) : acc_sum;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (cyc_eff == 2'd0) ? FIN : ACC;
            ACC:  if (last) state_nxt = FIN;
            FIN: begin
                state_nxt = IDLE;
                if (accept) state_nxt = (cyc_eff == 2'd0) ? FIN : ACC;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            acc      <= '0;
            rem      <= '0;
            idx      <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (accept) begin
            acc  <= bus.prod;
            op_q <= '{rs1: bus.rs1_u, rs2: bus.rs2_u, sign: bus.sign,
                      op: bus.mul_op, tag: bus.tag_in};
            rem  <= cyc_eff;
            idx  <= 2'd1;
            // init already negated prod for single-cycle ops, so it is final as-is
            if (cyc_eff == 2'd0) begin
                result_q <= pick_word(bus.prod, bus.mul_op);
                tag_q    <= bus.tag_in;
            end
        end else if (state == ACC && !bus.kill) begin
            acc <= acc_nxt;
            rem <= rem - 2'd1;
            idx <= idx + 2'd1;
            if (last) begin
                result_q <= pick_word(acc_nxt, op_q.op);
                tag_q    <= op_q.tag;
            end
        end
    end

    assign bus.ready   = ready;
    assign bus.done    = (state == FIN);
    assign bus.result  = result_q;
    assign bus.tag_out = tag_q;
endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative accumulate/finish stage for the M-extension multiplier. Sits directly downstream of the multiplier init stage.
- Captures the init stage's first partial sum `PROD`, unsigned operands, `SIGN` and `CYCLES`.
- Adds the remaining 11-bit chunks of `RS2_U` over 0–2 extra cycles, applies final negation and selects the low or high result word.
- Delivers a one-cycle `DONE` pulse with the 32-bit result and the destination tag to writeback.

Parameters:
- CHUNK, 11, number of `RS2_U` bits consumed per accumulate cycle; must match the init stage.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  init-stage outputs valid; accepted only when `READY`=1.
- KILL  in  1  synchronous abort (pipeline flush).
- PROD  in  64  first partial sum from init; already negated by init when `CYCLES`=0 and the result is negative.
- RS1_U  in  32  unsigned multiplicand magnitude.
- RS2_U  in  32  unsigned multiplier magnitude.
- SIGN  in  1  final product is negative.
- CYCLES  in  2  extra accumulate cycles needed: 0, 1 or 2 (3 illegal).
- MUL_OP  in  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
- TAG_IN  in  TAG_W  destination tag.
- READY  out  1  can accept `START` this cycle.
- DONE  out  1  one-cycle result-valid pulse.
- RESULT  out  32  selected product word.
- TAG_OUT  out  TAG_W  tag of the completing operation.

Behaviour:
- Reset (async, `RST_N`=0):
  - state=IDLE, `READY`=1, `DONE`=0.
  - `RESULT`=0, `TAG_OUT`=0, accumulator and internal registers=0.
- States: IDLE, ACC, FIN.
  - `READY`=1 in IDLE and FIN; 0 in ACC.
  - `DONE`=1 only in FIN.
- Accept (`START`=1 and `READY`=1, edge t):
  - Latch `PROD` into the 64-bit accumulator.
  - Latch `RS1_U`, `RS2_U`, `SIGN`, `MUL_OP`, `TAG_IN`.
  - Set remaining count = `CYCLES` and chunk index = 1.
  - If `CYCLES`=0: go to FIN; the accumulator is final. No negation here, even when `SIGN`=1.
  - If `CYCLES`≠0: go to ACC.
- ACC, each cycle:
  - acc += (`RS1_U` × `RS2_U`[idx·11 +: 11]) << (idx·11), 64-bit, zero-extended.
  - Chunk 2 covers bits [31:22] only (10 bits); bits above 31 are treated as 0.
  - Implement as a shift-add of the selected bits; no `*` operator.
  - Decrement the remaining count and increment the index.
  - On the last ACC cycle, if `SIGN`=1, the written value is the two's complement of the final sum (negate in the same cycle). Then go to FIN.
- FIN:
  - `RESULT` = acc[31:0] when `MUL_OP`=00; acc[63:32] otherwise.
  - `RESULT` and `TAG_OUT` are registered and held stable while `DONE`=1.
  - Next state: ACC or FIN if a new `START` is accepted this cycle (back-to-back); otherwise IDLE.
- Latency, `START` at edge t:
  - `CYCLES`=0: `DONE` in cycle t+1.
  - `CYCLES`=1: `DONE` in cycle t+2.
  - `CYCLES`=2: `DONE` in cycle t+3.
- `START` while `READY`=0: ignored; no state change.
- `KILL`=1:
  - Next state IDLE; no `DONE` is produced for the in-flight operation.
  - `KILL` has priority over a simultaneous `START`, which is dropped.
  - `KILL` in FIN does not suppress the current cycle's `DONE`; it only blocks the back-to-back accept.
- Reset asserted mid-operation: immediate return to the reset values; the operation is lost.
- `CYCLES`=3 (illegal): treat as 2.
- Accumulator arithmetic is modulo 2^64; no overflow flag.

Test Plan:
- MUL, `PROD`=15, `CYCLES`=0, `SIGN`=0, `TAG_IN`=7 → `DONE` at t+1, `RESULT`=0x0000000F, `TAG_OUT`=7, `READY`=1 throughout.
- MULH, `PROD`=0xFFFFFFFFFFFFFFFA (pre-negated −6), `CYCLES`=0, `SIGN`=1 → `RESULT`=0xFFFFFFFF at t+1 (no double negation).
- MUL, `RS1_U`=3, `RS2_U`=0x800, `PROD`=0, `CYCLES`=1, `SIGN`=1 → `READY`=0 at t+1, `DONE` at t+2, `RESULT`=0xFFFFE800.
- MULHU, `RS1_U`=`RS2_U`=0xFFFFFFFF, `PROD`=0xFFFFFFFF×0x7FF, `CYCLES`=2 → `DONE` at t+3, `RESULT`=0xFFFFFFFE; a second `START` with `CYCLES`=0 presented during FIN → its `DONE` at t+4.
- `CYCLES`=2 op started, `KILL` pulsed at t+1 together with a new `START` → no `DONE` ever, state IDLE at t+2, new `START` dropped.
- `CYCLES`=2 op started, `RST_N` low mid-ACC (asynchronously, between edges) → `DONE`/`RESULT`/`TAG_OUT`=0 and `READY`=1 immediately; the next op after reset release completes correctly.
